// File: rtl/io_map_pkg.sv
// Shared IO memory map for the CPU-side bridge: page base, register offsets,
// field widths and the address decoder used by io_bridge.
package io_map_pkg;

    localparam logic [19:0] IO_PAGE = 20'hFFFFF;

    localparam logic [11:0] OFS_DIG = 12'h000;
    localparam logic [11:0] OFS_LED = 12'h060;
    localparam logic [11:0] OFS_SW  = 12'h070;
    localparam logic [11:0] OFS_BTN = 12'h078;

    localparam int LED_W = 24;
    localparam int SW_W  = 24;
    localparam int BTN_W = 5;
    localparam int IN_W  = SW_W + BTN_W;

    typedef enum logic [2:0] {
        SEL_DRAM,
        SEL_DIG,
        SEL_LED,
        SEL_SW,
        SEL_BTN,
        SEL_NONE
    } io_sel_e;

    // Anything outside the IO page belongs to data RAM; unknown IO offsets map to SEL_NONE.
    function automatic io_sel_e io_decode(input logic [31:0] addr);
        io_sel_e sel;
        if (addr[31:12] != IO_PAGE) begin
            sel = SEL_DRAM;
        end else begin
            case (addr[11:0])
                OFS_DIG: sel = SEL_DIG;
                OFS_LED: sel = SEL_LED;
                OFS_SW:  sel = SEL_SW;
                OFS_BTN: sel = SEL_BTN;
                default: sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// One-bit input conditioner: SYNC_STAGES-deep synchronizer followed by a
// saturating-count debouncer that only accepts a level held DEBOUNCE_CYCLES+1 cycles.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 99999,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   stable_reg;
    logic                   stable_next;
    logic                   sync_out;

    assign sync_out = sync_reg[SYNC_STAGES-1];
    assign stable   = stable_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    // Any return to the accepted level restarts the count, so short glitches are dropped.
    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        if (sync_out == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            stable_next = sync_out;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
        end
    end

endmodule

// File: rtl/io_bridge.sv
// CPU data-port bridge: routes loads/stores either to data RAM or to the IO page
// (digit display, LED register, debounced switches and buttons).
module io_bridge
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 99999,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_addr,
    input  logic              cpu_wen,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic [31:0]       dram_addr,
    output logic              dram_wen,
    output logic [31:0]       dram_wdata,
    input  logic [31:0]       dram_rdata,
    output logic [11:0]       dig_addr,
    output logic              dig_wen,
    output logic [31:0]       dig_wdata,
    output logic [LED_W-1:0]  led,
    input  logic [SW_W-1:0]   sw,
    input  logic [BTN_W-1:0]  btn
);

    io_sel_e          sel;
    logic [LED_W-1:0] led_reg;
    logic [IN_W-1:0]  raw_in;
    logic [IN_W-1:0]  stable_vec;
    logic [SW_W-1:0]  sw_stable;
    logic [BTN_W-1:0] btn_stable;

    assign sel = io_decode(cpu_addr);

    assign dram_addr  = cpu_addr;
    assign dram_wdata = cpu_wdata;
    assign dram_wen   = (sel == SEL_DRAM) ? cpu_wen : 1'b0;

    assign dig_addr  = cpu_addr[11:0];
    assign dig_wdata = cpu_wdata;
    assign dig_wen   = (sel == SEL_DIG) ? cpu_wen : 1'b0;

    assign led = led_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg <= '0;
        end else if (sel == SEL_LED && cpu_wen) begin
            led_reg <= cpu_wdata[LED_W-1:0];
        end
    end

    // Switches occupy the low bits of the conditioner bank, buttons the top bits.
    assign raw_in     = {btn, sw};
    assign sw_stable  = stable_vec[SW_W-1:0];
    assign btn_stable = stable_vec[IN_W-1:SW_W];

    generate
        for (genvar gi = 0; gi < IN_W; gi++) begin : g_in
            io_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES)
            ) u_deb (
                .clk   (clk),
                .rst   (rst),
                .din   (raw_in[gi]),
                .stable(stable_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        cpu_rdata = 32'h0;
        case (sel)
            SEL_DRAM: cpu_rdata = dram_rdata;
            SEL_LED:  cpu_rdata = {{(32-LED_W){1'b0}}, led_reg};
            SEL_SW:   cpu_rdata = {{(32-SW_W){1'b0}}, sw_stable};
            SEL_BTN:  cpu_rdata = {{(32-BTN_W){1'b0}}, btn_stable};
            default:  cpu_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge with a short debounce window (4 cycles).
module tb_io_bridge;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + DEB + 1;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_wen;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [31:0] dram_addr;
    logic        dram_wen;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [11:0] dig_addr;
    logic        dig_wen;
    logic [31:0] dig_wdata;
    logic [23:0] led;
    logic [23:0] sw;
    logic [4:0]  btn;

    int tests;
    int failed;

    io_bridge #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wen   (cpu_wen),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .dram_addr (dram_addr),
        .dram_wen  (dram_wen),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .dig_addr  (dig_addr),
        .dig_wen   (dig_wen),
        .dig_wdata (dig_wdata),
        .led       (led),
        .sw        (sw),
        .btn       (btn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("[TB] %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        rst        = 1'b1;
        cpu_addr   = 32'h0;
        cpu_wen    = 1'b0;
        cpu_wdata  = 32'h0;
        dram_rdata = 32'h0;
        sw         = '0;
        btn        = '0;
        tick();
        tick();

        // Reset state
        cpu_addr = 32'hFFFF_F060;
        #1;
        check("rst_led", {8'h0, led}, 32'h0);
        check("rst_rd_led", cpu_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Digit display store: combinational, same cycle
        cpu_addr  = 32'hFFFF_F000;
        cpu_wen   = 1'b1;
        cpu_wdata = 32'h1234_5678;
        #1;
        check("dig_wen", {31'h0, dig_wen}, 32'h1);
        check("dig_addr", {20'h0, dig_addr}, 32'h0);
        check("dig_wdata", dig_wdata, 32'h1234_5678);
        check("dig_dram_wen", {31'h0, dram_wen}, 32'h0);
        check("dig_rd", cpu_rdata, 32'h0);

        // LED store, visible after one edge, read back zero-extended
        cpu_addr  = 32'hFFFF_F060;
        cpu_wdata = 32'hFFA5_A5A5;
        #1;
        check("led_dig_wen", {31'h0, dig_wen}, 32'h0);
        check("led_pre", {8'h0, led}, 32'h0);
        tick();
        cpu_wen = 1'b0;
        #1;
        check("led_post", {8'h0, led}, 32'h00A5_A5A5);
        check("led_rd", cpu_rdata, 32'h00A5_A5A5);

        // Writes to switch register and unmapped offsets must not disturb the LEDs
        cpu_addr  = 32'hFFFF_F070;
        cpu_wen   = 1'b1;
        cpu_wdata = 32'h0000_1111;
        tick();
        cpu_addr = 32'hFFFF_F100;
        tick();
        cpu_wen = 1'b0;
        #1;
        check("led_hold", {8'h0, led}, 32'h00A5_A5A5);

        // DRAM pass-through and unmapped IO read
        cpu_addr   = 32'h0000_0010;
        cpu_wen    = 1'b1;
        cpu_wdata  = 32'h0000_DEAD;
        dram_rdata = 32'hCAFE_BABE;
        #1;
        check("dram_wen", {31'h0, dram_wen}, 32'h1);
        check("dram_dig_wen", {31'h0, dig_wen}, 32'h0);
        check("dram_addr", dram_addr, 32'h0000_0010);
        check("dram_wdata", dram_wdata, 32'h0000_DEAD);
        check("dram_rd", cpu_rdata, 32'hCAFE_BABE);
        cpu_addr = 32'hFFFF_F100;
        #1;
        check("io_dram_wen", {31'h0, dram_wen}, 32'h0);
        check("unmap_rd", cpu_rdata, 32'h0);
        cpu_wen = 1'b0;
        tick();

        // Switch latency: 0 one cycle early, 1 exactly LAT edges after the change
        cpu_addr = 32'hFFFF_F070;
        sw       = 24'h000001;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == LAT - 1) check("sw_early", cpu_rdata, 32'h0);
            if (k == LAT)     check("sw_on_time", cpu_rdata, 32'h1);
        end

        // Button glitch of 3 cycles is rejected
        cpu_addr = 32'hFFFF_F078;
        btn      = 5'b00100;
        repeat (3) tick();
        btn = 5'b00000;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (cpu_rdata !== 32'h0 || k == 11) check("btn_glitch3", cpu_rdata, 32'h0);
        end

        // Glitch lasting exactly DEB cycles is still rejected
        cpu_addr = 32'hFFFF_F070;
        sw       = 24'h000021;
        repeat (DEB) tick();
        sw = 24'h000001;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (cpu_rdata !== 32'h1 || k == 11) check("sw_glitch4", cpu_rdata, 32'h1);
        end

        // Sustained button press is accepted
        cpu_addr = 32'hFFFF_F078;
        btn      = 5'b10000;
        repeat (LAT) tick();
        check("btn_press", cpu_rdata, 32'h0000_0010);
        btn = 5'b00000;
        repeat (LAT) tick();
        check("btn_release", cpu_rdata, 32'h0);

        // Prepare: led=0x00FF00, switches back to 0
        cpu_addr  = 32'hFFFF_F060;
        cpu_wen   = 1'b1;
        cpu_wdata = 32'h0000_FF00;
        sw        = 24'h0;
        tick();
        cpu_wen = 1'b0;
        #1;
        check("led_ff00", {8'h0, led}, 32'h0000_FF00);
        repeat (LAT + 2) tick();

        // Start a debounce, then hit reset mid-way
        cpu_addr = 32'hFFFF_F070;
        sw       = 24'h000001;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_led", {8'h0, led}, 32'h0);
        check("rst_sw_rd", cpu_rdata, 32'h0);
        cpu_addr   = 32'h0000_0044;
        dram_rdata = 32'h5555_AAAA;
        #1;
        check("rst_comb_rd", cpu_rdata, 32'h5555_AAAA);
        check("rst_comb_addr", dram_addr, 32'h0000_0044);

        // LED write during reset is discarded
        cpu_addr  = 32'hFFFF_F060;
        cpu_wen   = 1'b1;
        cpu_wdata = 32'h00FF_FFFF;
        tick();
        cpu_wen = 1'b0;
        #1;
        check("rst_led_wr", {8'h0, led}, 32'h0);
        rst      = 1'b0;
        cpu_addr = 32'hFFFF_F070;

        // Debounce restarts from zero after release
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == LAT - 1) check("post_rst_early", cpu_rdata, 32'h0);
            if (k == LAT)     check("post_rst_sw", cpu_rdata, 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 99999, gives the number of consecutive stable clk cycles required before a switch/button input is accepted (2 ms at 50 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, gives the input synchronizer depth.
REQ-003 clk  input  1  sole clock; all state is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cpu_addr  input  32  byte address from the CPU MEM stage.
REQ-006 cpu_wen  input  1  CPU store strobe.
REQ-007 cpu_wdata  input  32  CPU store data.
REQ-008 cpu_rdata  output  32  load data returned to the CPU.
REQ-009 dram_addr  output  32  address forwarded to data RAM.
REQ-010 dram_wen  output  1  data RAM write enable.
REQ-011 dram_wdata  output  32  data RAM write data.
REQ-012 dram_rdata  input  32  data RAM read data.
REQ-013 dig_addr  output  12  digit-display offset (cpu_addr[11:0]).
REQ-014 dig_wen  output  1  digit-display write enable.
REQ-015 dig_wdata  output  32  digit-display data.
REQ-016 led  output  24  LED register, active-high.
REQ-017 sw  input  24  raw asynchronous switch levels.
REQ-018 btn  input  5  raw asynchronous button levels.

Function
REQ-019 IO page: cpu_addr[31:12]==20'hFFFFF; all other addresses are DRAM.
REQ-020 DRAM addresses: dram_wen=cpu_wen, dram_addr=cpu_addr, dram_wdata=cpu_wdata, cpu_rdata=dram_rdata, all combinational, zero latency.
REQ-021 IO page: dram_wen=0 regardless of cpu_wen.
REQ-022 Offset 0x000: dig_wen=cpu_wen, same cycle, combinational; dig_addr and dig_wdata always mirror cpu_addr[11:0] and cpu_wdata; dig_wen=0 at every other address.
REQ-023 Offset 0x060 write: led<=cpu_wdata[23:0] on the next rising edge; led holds otherwise.
REQ-024 Offset 0x060 read: cpu_rdata={8'h0,led}.
REQ-025 Offset 0x070 read: cpu_rdata={8'h0,sw_stable}; writes are ignored.
REQ-026 Offset 0x078 read: cpu_rdata={27'h0,btn_stable}; writes are ignored.
REQ-027 Offset 0x000 read and any unmapped IO offset read return 32'h0; unmapped writes have no effect.
REQ-028 Each sw/btn bit passes through a SYNC_STAGES flip-flop synchronizer, then its own debouncer.
REQ-029 Debouncer: synchronized value equal to stable value -> counter clears to 0.
REQ-030 Debouncer: values differ and counter<DEBOUNCE_CYCLES -> counter increments.
REQ-031 Debouncer: values differ and counter==DEBOUNCE_CYCLES -> stable takes the synchronized value and the counter clears.
REQ-032 Input latency is therefore SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles from a clean edge to stable.
REQ-033 A glitch lasting no more than DEBOUNCE_CYCLES cycles never changes stable.
REQ-034 Counter width is $clog2(DEBOUNCE_CYCLES+1); the counter never wraps.
REQ-035 Decode uses only cpu_addr; cpu_wen gates writes only; reads have no side effects.

Reset
REQ-036 rst asynchronously forces led=0, all synchronizer flops=0, all stable values=0 and all debounce counters=0.
REQ-037 Combinational outputs follow inputs during reset; an LED write coincident with rst is discarded.
REQ-038 A debounce in progress when rst asserts is abandoned; after release it restarts from count 0.

Structure
REQ-039 Shared package io_map_pkg holds the IO page base 20'hFFFFF, offsets 12'h000/12'h060/12'h070/12'h078, and widths 24 (led/sw) and 5 (btn).
REQ-040 Sub-module io_debounce (one bit: synchronizer + counter + stable flop, parameters DEBOUNCE_CYCLES and SYNC_STAGES) is instantiated 29 times by generate.

Verification (DEBOUNCE_CYCLES=4)
REQ-041 Store 0xFFFF_F000 data 0x12345678 -> dig_wen=1 in the same cycle with dig_addr=0x000 and dig_wdata=0x12345678; dram_wen=0.
REQ-042 Store 0xFFFF_F060 data 0xFFA5A5A5, then load 0xFFFF_F060 -> led=0xA5A5A5 after one edge; cpu_rdata=0x00A5A5A5.
REQ-043 sw 0 -> 0x000001 held steady -> load 0xFFFF_F070 returns 0x1 exactly SYNC_STAGES+5 cycles later and 0x0 one cycle earlier.
REQ-044 btn[2] high for 3 cycles, then low -> btn_stable never changes; load 0xFFFF_F078 returns 0x0.
REQ-045 Store 0x0000_0010 data 0xDEAD -> dram_wen=1 and dig_wen=0; load 0xFFFF_F100 -> cpu_rdata=0.
REQ-046 Assert rst mid-debounce and after led=0x00FF00 -> led=0 immediately; with sw held at 1 after release, stable rises only after a full SYNC_STAGES+5 cycles.
